// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end.
//   NOP_INSTR        : canonical bubble instruction (addi x0,x0,0)
//   DEFAULT_RESET_PC : default PC loaded on reset
//   fetch_state_t    : fetch FSM states
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        REDIR_PEND = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst                    : core clock, async active-high reset
//   load                        : capture instr/pc/pcplus4 as a valid entry
//   bubble                      : insert a NOP bubble (PC fields keep old values)
//   hold                        : keep current contents
//   instr, pc, pcplus4          : fetched word and its PCs
//   instrd, pcd, pcplus4d, validd : registered outputs to Decode
// Priority: bubble > hold > load; with none asserted the register keeps its value.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic        hold,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] pcplus4,
    output logic [31:0] instrd,
    output logic [31:0] pcd,
    output logic [31:0] pcplus4d,
    output logic        validd
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrd   <= NOP_INSTR;
            pcd      <= 32'h0;
            pcplus4d <= 32'h0;
            validd   <= 1'b0;
        end else if (bubble) begin
            instrd <= NOP_INSTR;
            validd <= 1'b0;
        end else if (load && !hold) begin
            instrd   <= instr;
            pcd      <= pc;
            pcplus4d <= pcplus4;
            validd   <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, redirect FSM and IF/ID register.
// Ports:
//   clk, rst          : core clock, async active-high reset
//   Stall, Flush      : hazard unit controls (hold / bubble IF/ID)
//   PCSrc, PCTarget   : redirect request and target from EX
//   ImemReq, ImemAddr : instruction memory request and address (= PCF)
//   ImemRdata, ImemReady : memory response; fetch completes when ImemReq & ImemReady
//   InstrD, PCD, PCPlus4D, ValidD : IF/ID register outputs to Decode
//
// state      | meaning
// RUN        | normal sequential fetch
// REDIR_PEND | redirect taken during a wait state; in-flight fetch is wrong-path
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemRdata,
    input  logic        ImemReady,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    fetch_state_t state;
    logic [31:0]  pcf;
    logic [31:0]  redir_pc;
    logic [31:0]  pcf_plus4;
    logic [31:0]  target;
    logic         fetch_done;
    logic         ifid_load;
    logic         ifid_bubble;
    logic         ifid_hold;

    assign target     = PCTarget & 32'hFFFF_FFFC;
    assign pcf_plus4  = pcf + 32'd4;
    // ImemReady is ignored until the request line is actually up.
    assign fetch_done = ImemReq & ImemReady;
    assign ImemAddr   = pcf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            pcf      <= RESET_PC;
            redir_pc <= 32'h0;
            ImemReq  <= 1'b0;
        end else begin
            ImemReq <= 1'b1;
            case (state)
                RUN: begin
                    if (PCSrc && fetch_done) begin
                        pcf <= target;
                    end else if (PCSrc) begin
                        redir_pc <= target;
                        state    <= REDIR_PEND;
                    end else if (!Stall && fetch_done) begin
                        pcf <= pcf_plus4;
                    end
                end
                REDIR_PEND: begin
                    if (PCSrc)
                        redir_pc <= target;
                    // A redirect arriving in the completing cycle is the newest one.
                    if (fetch_done) begin
                        pcf   <= PCSrc ? target : redir_pc;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_hold   = 1'b0;
        if (state == RUN) begin
            if (PCSrc && fetch_done) begin
                ifid_bubble = 1'b1;
            end else if (Stall) begin
                // Covers PCSrc with a pending fetch too: Stall holds, Flush still bubbles.
                if (Flush) ifid_bubble = 1'b1;
                else       ifid_hold   = 1'b1;
            end else if (!PCSrc && fetch_done && !Flush) begin
                ifid_load = 1'b1;
            end else begin
                ifid_bubble = 1'b1;
            end
        end else begin
            if (Stall && !Flush) ifid_hold   = 1'b1;
            else                 ifid_bubble = 1'b1;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .hold     (ifid_hold),
        .instr    (ImemRdata),
        .pc       (pcf),
        .pcplus4  (pcf_plus4),
        .instrd   (InstrD),
        .pcd      (PCD),
        .pcplus4d (PCPlus4D),
        .validd   (ValidD)
    );

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined RISC-V core. It holds the PC, drives the instruction-memory request, and absorbs memory wait states. It applies stall, flush and branch/jump redirects, then registers the fetched word for Decode. That word feeds the immediate generator (Instr[31:7]) and the control decoder.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  core clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- Stall  in  1  hazard unit: hold PCF and IF/ID
- Flush  in  1  hazard unit: bubble IF/ID
- PCSrc  in  1  redirect request from EX (taken branch/jump)
- PCTarget  in  32  redirect address; bits [1:0] ignored (treated as 00)
- ImemReq  out  1  fetch request
- ImemAddr  out  32  fetch address (= PCF)
- ImemRdata  in  32  fetched word, valid when ImemReady=1
- ImemReady  in  1  fetch for ImemAddr completes this cycle
- InstrD  out  32  registered instruction to Decode
- PCD  out  32  PC of InstrD
- PCPlus4D  out  32  PCD + 4
- ValidD  out  1  InstrD is a real instruction (0 = bubble)

## Operation
- FSM states: RUN, REDIR_PEND. RedirPC is a 32-bit holding register.
- ImemReq: registered; 0 in reset, 1 from the first clk edge after reset release, then constant.
- ImemAddr = PCF. It must stay stable while ImemReq=1 and ImemReady=0.
- Fetch completes in a cycle with ImemReq=1 and ImemReady=1.

RUN, per cycle, in priority order:
1. PCSrc=1 and ImemReady=1 → PCF←{PCTarget[31:2],2'b00}; IF/ID←bubble.
2. PCSrc=1 and ImemReady=0 → RedirPC←{PCTarget[31:2],2'b00}; go to REDIR_PEND; PCF held; IF/ID←bubble unless Stall.
3. Stall=1 → PCF and IF/ID held. If Flush is also 1, IF/ID←bubble. A completing fetch is dropped and re-issued from the same PCF.
4. ImemReady=1 → PCF←PCF+4; IF/ID←{ImemRdata, PCF, PCF+4, Valid=1}, or bubble if Flush=1.
5. ImemReady=0 → PCF held; IF/ID←bubble (unless Stall).

REDIR_PEND:
- The in-flight fetch is wrong-path; its data is never loaded.
- IF/ID←bubble each cycle (Stall holds it instead, Flush still bubbles).
- On ImemReady=1: PCF←RedirPC; go to RUN.
- A new PCSrc in this state overwrites RedirPC; the last one wins.

Bubble and arithmetic rules:
- Bubble: InstrD←32'h0000_0013 (addi x0,x0,0), ValidD←0. PCD and PCPlus4D keep their old values.
- PC arithmetic is mod 2^32: PCF=32'hFFFF_FFFC advances to 32'h0000_0000.

## Timing
Reset values (asynchronous):
- PCF=RESET_PC
- ImemReq=0
- InstrD=32'h0000_0013
- PCD=0, PCPlus4D=0, ValidD=0
- state=RUN, RedirPC=0
- Asserting rst mid-fetch or in REDIR_PEND abandons all state immediately.

Latency and throughput:
- With a zero-wait memory, a word fetched at PCF appears on InstrD one cycle later.
- Sustained rate is one instruction per cycle.
- Redirect penalty: with PCSrc asserted in cycle N (zero wait), ImemAddr=PCTarget in cycle N+1 and the target instruction is on InstrD in cycle N+2.
- Each memory wait cycle inserts one bubble.

Edge cases:
- Flush and Stall together: Flush wins for IF/ID; Stall still holds PCF.
- PCSrc and Stall together: PCSrc wins for PCF.

## Structure
- Shared package riscv_pkg:
  - NOP_INSTR = 32'h0000_0013
  - default RESET_PC
  - fetch FSM state enum (RUN, REDIR_PEND)
- Sub-module if_id_reg: the IF/ID register (InstrD, PCD, PCPlus4D, ValidD).
  - Inputs: load, bubble, hold.
  - Asynchronous reset to the bubble values above.
- PC register, FSM and RedirPC live in if_stage.

## Test plan
- Reset with RESET_PC=32'h0000_1000; release; ImemReady held 1 → ImemReq rises after one edge; ImemAddr sequence 1000, 1004, 1008; InstrD follows one cycle later with ValidD=1.
- ImemReady low for 3 cycles at PCF=32'h0000_0008 → ImemAddr stays 0x8; 3 bubbles (InstrD=0x13, ValidD=0); then the word from 0x8 with PCD=0x8.
- PCSrc=1, PCTarget=32'h0000_0203, zero wait → next ImemAddr=0x200; the wrong-path word is never ValidD=1.
- PCSrc during a wait state, PCTarget=0x400, ImemReady returns 2 cycles later → REDIR_PEND entered; the stale word is discarded; next ImemAddr=0x400.
- Stall for 2 cycles with PCD=0x10 → InstrD, PCD and ImemAddr frozen. Stall+Flush in the same cycle → ValidD=0, InstrD=0x13, PCF held.
- PCF=32'hFFFF_FFFC, ImemReady=1 → next ImemAddr=0, PCPlus4D=0 for that word. Assert rst mid-wait → all outputs return to their reset values asynchronously.
